dispatch_unit: RTL and testbench

Dispatch stage between rename/decode and the reservation station. It accepts one renamed instruction per cycle and reads source operands from the physical register file, bypassing from the common data bus (CDB). It tracks operand readiness in a 64-entry scoreboard, allocates ROB numbers and a round-robin functional-unit number, and issues a registered one-cycle-valid entry to the reservation station. It stalls rename when the reservation station has no free credit or the ROB is full.

---
 rtl/dispatch_unit.sv | 177 +++++++++++++++++
 tb/tb_dispatch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_unit.sv
// Dispatch stage: resolves renamed source operands against the PRF, CDB and a
// readiness scoreboard, allocates ROB/FU numbers and issues one registered RS entry per cycle.
module dispatch_unit #(
    parameter int RS_SIZE  = 64,
    parameter int ROB_SIZE = 64,
    parameter int NUM_FU   = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_physical_rd,
    input  logic [5:0]  in_physical_rs1,
    input  logic [5:0]  in_physical_rs2,
    input  logic [3:0]  in_ALUControl,
    input  logic [31:0] in_imm,
    input  logic        in_LoadStore,
    input  logic        in_ALUSrc,
    input  logic        in_RegWrite,
    input  logic        in_BMS,

    output logic [5:0]  prf_rs1_addr,
    output logic [5:0]  prf_rs2_addr,
    input  logic [31:0] prf_rs1_data,
    input  logic [31:0] prf_rs2_data,

    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_value,

    input  logic        rs_free,
    input  logic        rob_retire,

    output logic        out_valid,
    output logic [5:0]  out_physical_rd,
    output logic [5:0]  out_physical_rs1,
    output logic [5:0]  out_physical_rs2,
    output logic [31:0] out_rs1_value,
    output logic [31:0] out_rs2_value,
    output logic        out_rs1_ready,
    output logic        out_rs2_ready,
    output logic [3:0]  out_ALUControl,
    output logic [31:0] out_imm,
    output logic        out_LoadStore,
    output logic        out_ALUSrc,
    output logic        out_RegWrite,
    output logic        out_BMS,
    output logic [1:0]  out_FU_num,
    output logic [5:0]  out_ROB_num,

    output logic [6:0]  rs_credits,
    output logic [6:0]  rob_count
);

    localparam logic [6:0] RS_FULL  = 7'(RS_SIZE);
    localparam logic [6:0] ROB_FULL = 7'(ROB_SIZE);
    localparam logic [1:0] FU_LAST  = 2'(NUM_FU - 1);

    logic [63:0] scoreboard;
    logic [63:0] scoreboard_next;
    logic [5:0]  rob_tail;
    logic [1:0]  fu_ptr;
    logic        fire;
    logic [32:0] rs1_resolved;
    logic [32:0] rs2_resolved;

    // Returns {ready, value}; the CDB bypass covers a producer writing back this very cycle.
    function automatic logic [32:0] resolve(
        input logic [5:0]  tag,
        input logic [31:0] prf_data,
        input logic [63:0] sb,
        input logic        bus_valid,
        input logic [5:0]  bus_tag,
        input logic [31:0] bus_value
    );
        if (tag == 6'd0)
            resolve = {1'b1, 32'd0};
        else if (bus_valid && bus_tag == tag)
            resolve = {1'b1, bus_value};
        else
            resolve = {sb[tag], prf_data};
    endfunction

    assign in_ready     = (rs_credits != 7'd0) && (rob_count != ROB_FULL);
    assign fire         = in_valid && in_ready;
    assign prf_rs1_addr = in_physical_rs1;
    assign prf_rs2_addr = in_physical_rs2;

    always_comb begin
        rs1_resolved = resolve(in_physical_rs1, prf_rs1_data, scoreboard, cdb_valid, cdb_tag, cdb_value);
        rs2_resolved = resolve(in_physical_rs2, prf_rs2_data, scoreboard, cdb_valid, cdb_tag, cdb_value);
    end

    // A new producer's clear is applied after the CDB set so it wins a same-tag collision.
    always_comb begin
        scoreboard_next = scoreboard;
        if (cdb_valid)
            scoreboard_next[cdb_tag] = 1'b1;
        if (fire && in_RegWrite && in_physical_rd != 6'd0)
            scoreboard_next[in_physical_rd] = 1'b0;
        scoreboard_next[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scoreboard <= '1;
        else
            scoreboard <= scoreboard_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_credits <= RS_FULL;
            rob_count  <= 7'd0;
            rob_tail   <= 6'd0;
            fu_ptr     <= 2'd0;
        end else begin
            if (fire && !rs_free)
                rs_credits <= rs_credits - 7'd1;
            else if (!fire && rs_free && rs_credits != RS_FULL)
                rs_credits <= rs_credits + 7'd1;

            if (fire && !rob_retire)
                rob_count <= rob_count + 7'd1;
            else if (!fire && rob_retire && rob_count != 7'd0)
                rob_count <= rob_count - 7'd1;

            if (fire) begin
                rob_tail <= rob_tail + 6'd1;
                fu_ptr   <= (fu_ptr == FU_LAST) ? 2'd0 : fu_ptr + 2'd1;
            end
        end
    end

    // Output fields hold their last value between fires; only the strobe drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid        <= 1'b0;
            out_physical_rd  <= 6'd0;
            out_physical_rs1 <= 6'd0;
            out_physical_rs2 <= 6'd0;
            out_rs1_value    <= 32'd0;
            out_rs2_value    <= 32'd0;
            out_rs1_ready    <= 1'b0;
            out_rs2_ready    <= 1'b0;
            out_ALUControl   <= 4'd0;
            out_imm          <= 32'd0;
            out_LoadStore    <= 1'b0;
            out_ALUSrc       <= 1'b0;
            out_RegWrite     <= 1'b0;
            out_BMS          <= 1'b0;
            out_FU_num       <= 2'd0;
            out_ROB_num      <= 6'd0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                out_physical_rd  <= in_physical_rd;
                out_physical_rs1 <= in_physical_rs1;
                out_physical_rs2 <= in_physical_rs2;
                out_rs1_ready    <= rs1_resolved[32];
                out_rs1_value    <= rs1_resolved[31:0];
                out_rs2_ready    <= rs2_resolved[32];
                out_rs2_value    <= rs2_resolved[31:0];
                out_ALUControl   <= in_ALUControl;
                out_imm          <= in_imm;
                out_LoadStore    <= in_LoadStore;
                out_ALUSrc       <= in_ALUSrc;
                out_RegWrite     <= in_RegWrite;
                out_BMS          <= in_BMS;
                out_FU_num       <= fu_ptr;
                out_ROB_num      <= rob_tail;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed testbench for dispatch_unit: inputs are driven and outputs sampled on the
// falling clock edge, with expected values computed by hand for each scenario.
module tb_dispatch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_physical_rd, in_physical_rs1, in_physical_rs2;
    logic [3:0]  in_ALUControl;
    logic [31:0] in_imm;
    logic        in_LoadStore, in_ALUSrc, in_RegWrite, in_BMS;
    logic [5:0]  prf_rs1_addr, prf_rs2_addr;
    logic [31:0] prf_rs1_data, prf_rs2_data;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        rs_free, rob_retire;
    logic        out_valid;
    logic [5:0]  out_physical_rd, out_physical_rs1, out_physical_rs2;
    logic [31:0] out_rs1_value, out_rs2_value;
    logic        out_rs1_ready, out_rs2_ready;
    logic [3:0]  out_ALUControl;
    logic [31:0] out_imm;
    logic        out_LoadStore, out_ALUSrc, out_RegWrite, out_BMS;
    logic [1:0]  out_FU_num;
    logic [5:0]  out_ROB_num;
    logic [6:0]  rs_credits, rob_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dispatch_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_physical_rd(in_physical_rd), .in_physical_rs1(in_physical_rs1),
        .in_physical_rs2(in_physical_rs2), .in_ALUControl(in_ALUControl), .in_imm(in_imm),
        .in_LoadStore(in_LoadStore), .in_ALUSrc(in_ALUSrc), .in_RegWrite(in_RegWrite),
        .in_BMS(in_BMS),
        .prf_rs1_addr(prf_rs1_addr), .prf_rs2_addr(prf_rs2_addr),
        .prf_rs1_data(prf_rs1_data), .prf_rs2_data(prf_rs2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs_free(rs_free), .rob_retire(rob_retire),
        .out_valid(out_valid), .out_physical_rd(out_physical_rd),
        .out_physical_rs1(out_physical_rs1), .out_physical_rs2(out_physical_rs2),
        .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
        .out_rs1_ready(out_rs1_ready), .out_rs2_ready(out_rs2_ready),
        .out_ALUControl(out_ALUControl), .out_imm(out_imm),
        .out_LoadStore(out_LoadStore), .out_ALUSrc(out_ALUSrc),
        .out_RegWrite(out_RegWrite), .out_BMS(out_BMS),
        .out_FU_num(out_FU_num), .out_ROB_num(out_ROB_num),
        .rs_credits(rs_credits), .rob_count(rob_count)
    );

    task automatic set_in(input logic v, input logic [5:0] rd, input logic [5:0] rs1,
                          input logic [5:0] rs2, input logic rw);
        in_valid        = v;
        in_physical_rd  = rd;
        in_physical_rs1 = rs1;
        in_physical_rs2 = rs2;
        in_RegWrite     = rw;
    endtask

    task automatic do_reset();
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        in_ALUControl = 4'd0; in_imm = 32'd0;
        in_LoadStore = 1'b0; in_ALUSrc = 1'b0; in_BMS = 1'b0;
        prf_rs1_data = 32'd0; prf_rs2_data = 32'd0;
        cdb_valid = 1'b0; cdb_tag = 6'd0; cdb_value = 32'd0;
        rs_free = 1'b0; rob_retire = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        compared++; if (rs_credits !== 7'd64) begin mismatched++; $display("[TB] FAIL reset_rs_credits: got %0d expected 64", rs_credits); end
        compared++; if (rob_count !== 7'd0) begin mismatched++; $display("[TB] FAIL reset_rob_count: got %0d expected 0", rob_count); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        compared++; if (out_imm !== 32'd0 || out_ROB_num !== 6'd0) begin mismatched++; $display("[TB] FAIL reset_fields: got imm=%h rob=%0d expected 0/0", out_imm, out_ROB_num); end
        // Saturation: rs_free at full credit and retire at empty ROB are ignored.
        rs_free = 1'b1; rob_retire = 1'b1;
        @(negedge clk);
        rs_free = 1'b0; rob_retire = 1'b0;
        compared++; if (rs_credits !== 7'd64) begin mismatched++; $display("[TB] FAIL credit_saturate: got %0d expected 64", rs_credits); end
        compared++; if (rob_count !== 7'd0) begin mismatched++; $display("[TB] FAIL retire_at_zero: got %0d expected 0", rob_count); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_fu [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 6'(i + 1), 6'd0, 6'd0, 1'b0);
            @(negedge clk);
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid%0d: got %0b expected 1", i, out_valid); end
            compared++; if (out_ROB_num !== 6'(i)) begin mismatched++; $display("[TB] FAIL b2b_rob%0d: got %0d expected %0d", i, out_ROB_num, i); end
            compared++; if (out_FU_num !== exp_fu[i]) begin mismatched++; $display("[TB] FAIL b2b_fu%0d: got %0d expected %0d", i, out_FU_num, exp_fu[i]); end
            compared++; if (out_physical_rd !== 6'(i + 1)) begin mismatched++; $display("[TB] FAIL b2b_rd%0d: got %0d expected %0d", i, out_physical_rd, i + 1); end
        end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_valid: got %0b expected 0", out_valid); end
        compared++; if (out_ROB_num !== 6'd3) begin mismatched++; $display("[TB] FAIL b2b_hold_rob: got %0d expected 3", out_ROB_num); end
        compared++; if (rs_credits !== 7'd60 || rob_count !== 7'd4) begin mismatched++; $display("[TB] FAIL b2b_counters: got credits=%0d rob=%0d expected 60/4", rs_credits, rob_count); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        prf_rs1_data = 32'h1111_2222; prf_rs2_data = 32'h3333_4444;
        set_in(1'b1, 6'd5, 6'd0, 6'd0, 1'b1);
        @(negedge clk);
        set_in(1'b1, 6'd0, 6'd5, 6'd5, 1'b0);
        @(negedge clk);
        compared++; if (out_rs1_ready !== 1'b0 || out_rs2_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL sb_pending: got r1=%0b r2=%0b expected 0/0", out_rs1_ready, out_rs2_ready); end
        compared++; if (out_rs1_value !== 32'h1111_2222 || out_rs2_value !== 32'h3333_4444) begin mismatched++; $display("[TB] FAIL sb_prf_values: got %h/%h expected 11112222/33334444", out_rs1_value, out_rs2_value); end
        set_in(1'b1, 6'd0, 6'd5, 6'd0, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_value = 32'hDEAD_BEEF;
        @(negedge clk);
        cdb_valid = 1'b0;
        compared++; if (out_rs1_ready !== 1'b1 || out_rs1_value !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL cdb_bypass: got r=%0b v=%h expected 1/deadbeef", out_rs1_ready, out_rs1_value); end
        compared++; if (out_rs2_ready !== 1'b1 || out_rs2_value !== 32'd0) begin mismatched++; $display("[TB] FAIL tag0_rs2: got r=%0b v=%h expected 1/0", out_rs2_ready, out_rs2_value); end
        @(negedge clk);
        compared++; if (out_rs1_ready !== 1'b1 || out_rs1_value !== 32'h1111_2222) begin mismatched++; $display("[TB] FAIL sb_set_by_cdb: got r=%0b v=%h expected 1/11112222", out_rs1_ready, out_rs1_value); end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic test_cdb_clear_race();
        do_reset();
        prf_rs1_data = 32'h0000_ABCD;
        set_in(1'b1, 6'd7, 6'd7, 6'd0, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_value = 32'h0000_0077;
        @(negedge clk);
        cdb_valid = 1'b0;
        compared++; if (out_rs1_ready !== 1'b1 || out_rs1_value !== 32'h77) begin mismatched++; $display("[TB] FAIL race_bypass: got r=%0b v=%h expected 1/77", out_rs1_ready, out_rs1_value); end
        set_in(1'b1, 6'd0, 6'd7, 6'd0, 1'b0);
        @(negedge clk);
        compared++; if (out_rs1_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL race_clear_wins: got %0b expected 0", out_rs1_ready); end
        set_in(1'b1, 6'd9, 6'd9, 6'd0, 1'b1);
        @(negedge clk);
        compared++; if (out_rs1_ready !== 1'b1 || out_rs1_value !== 32'h0000_ABCD) begin mismatched++; $display("[TB] FAIL rs_eq_rd_old: got r=%0b v=%h expected 1/0000abcd", out_rs1_ready, out_rs1_value); end
        set_in(1'b1, 6'd0, 6'd9, 6'd0, 1'b0);
        @(negedge clk);
        compared++; if (out_rs1_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rs_eq_rd_new: got %0b expected 0", out_rs1_ready); end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic test_credits();
        do_reset();
        rob_retire = 1'b1;
        for (int i = 0; i < 64; i++) begin
            set_in(1'b1, 6'd0, 6'd0, 6'd0, 1'b0);
            @(negedge clk);
        end
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        rob_retire = 1'b0;
        compared++; if (rs_credits !== 7'd0 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL credits_empty: got credits=%0d ready=%0b expected 0/0", rs_credits, in_ready); end
        compared++; if (rob_count !== 7'd0) begin mismatched++; $display("[TB] FAIL fire_and_retire: got %0d expected 0", rob_count); end
        in_valid = 1'b1; rs_free = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL same_cycle_unstall: got %0b expected 0", in_ready); end
        @(negedge clk);
        rs_free = 1'b0;
        compared++; if (out_valid !== 1'b0 || rs_credits !== 7'd1 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL credit_return: got v=%0b credits=%0d ready=%0b expected 0/1/1", out_valid, rs_credits, in_ready); end
        rs_free = 1'b1;
        @(negedge clk);
        rs_free = 1'b0; in_valid = 1'b0;
        compared++; if (out_valid !== 1'b1 || rs_credits !== 7'd1) begin mismatched++; $display("[TB] FAIL fire_and_free: got v=%0b credits=%0d expected 1/1", out_valid, rs_credits); end
    endtask

    task automatic test_rob_wrap();
        do_reset();
        rs_free = 1'b1;
        for (int i = 0; i < 64; i++) begin
            set_in(1'b1, 6'd0, 6'd0, 6'd0, 1'b0);
            @(negedge clk);
        end
        rs_free = 1'b0;
        compared++; if (out_ROB_num !== 6'd63 || out_FU_num !== 2'd0) begin mismatched++; $display("[TB] FAIL rob_last: got rob=%0d fu=%0d expected 63/0", out_ROB_num, out_FU_num); end
        compared++; if (rob_count !== 7'd64 || rs_credits !== 7'd64 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rob_full: got count=%0d credits=%0d ready=%0b expected 64/64/0", rob_count, rs_credits, in_ready); end
        rob_retire = 1'b1;
        @(negedge clk);
        rob_retire = 1'b0;
        compared++; if (out_valid !== 1'b0 || rob_count !== 7'd63 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rob_retire: got v=%0b count=%0d ready=%0b expected 0/63/1", out_valid, rob_count, in_ready); end
        @(negedge clk);
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        compared++; if (out_valid !== 1'b1 || out_ROB_num !== 6'd0 || out_FU_num !== 2'd1) begin mismatched++; $display("[TB] FAIL rob_wrap: got v=%0b rob=%0d fu=%0d expected 1/0/1", out_valid, out_ROB_num, out_FU_num); end
    endtask

    task automatic test_zero_tags();
        do_reset();
        prf_rs1_data = 32'h1234; prf_rs2_data = 32'h1234;
        in_ALUControl = 4'hC; in_imm = 32'hA5A5_0001;
        in_LoadStore = 1'b1; in_ALUSrc = 1'b0; in_BMS = 1'b1;
        set_in(1'b1, 6'd0, 6'd42, 6'd17, 1'b1);
        #1;
        compared++; if (prf_rs1_addr !== 6'd42 || prf_rs2_addr !== 6'd17) begin mismatched++; $display("[TB] FAIL prf_addr: got %0d/%0d expected 42/17", prf_rs1_addr, prf_rs2_addr); end
        set_in(1'b1, 6'd0, 6'd0, 6'd0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        compared++; if (out_rs1_value !== 32'd0 || out_rs2_value !== 32'd0 || out_rs1_ready !== 1'b1 || out_rs2_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_tags: got %h/%h r=%0b%0b expected 0/0 r=11", out_rs1_value, out_rs2_value, out_rs1_ready, out_rs2_ready); end
        compared++; if (out_imm !== 32'hA5A5_0001 || out_ALUControl !== 4'hC) begin mismatched++; $display("[TB] FAIL payload: got imm=%h alu=%h expected a5a50001/c", out_imm, out_ALUControl); end
        compared++; if ({out_LoadStore, out_ALUSrc, out_RegWrite, out_BMS} !== 4'b1011) begin mismatched++; $display("[TB] FAIL flags: got %b expected 1011", {out_LoadStore, out_ALUSrc, out_RegWrite, out_BMS}); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        in_imm = 32'h0BAD_F00D;
        set_in(1'b1, 6'd3, 6'd0, 6'd0, 1'b1);
        repeat (2) @(negedge clk);
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        compared++; if (out_valid !== 1'b1 || out_ROB_num !== 6'd1) begin mismatched++; $display("[TB] FAIL pre_reset: got v=%0b rob=%0d expected 1/1", out_valid, out_ROB_num); end
        #1 reset = 1'b1;
        #1;
        compared++; if (out_valid !== 1'b0 || out_imm !== 32'd0) begin mismatched++; $display("[TB] FAIL async_reset: got v=%0b imm=%h expected 0/0", out_valid, out_imm); end
        compared++; if (rs_credits !== 7'd64 || rob_count !== 7'd0) begin mismatched++; $display("[TB] FAIL async_reset_counters: got %0d/%0d expected 64/0", rs_credits, rob_count); end
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b1, 6'd0, 6'd3, 6'd0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        compared++; if (out_ROB_num !== 6'd0 || out_FU_num !== 2'd0 || out_rs1_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset: got rob=%0d fu=%0d r1=%0b expected 0/0/1", out_ROB_num, out_FU_num, out_rs1_ready); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_scoreboard();
        test_cdb_clear_race();
        test_credits();
        test_rob_wrap();
        test_zero_tags();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
